// File: rtl/matmul_seq_pkg.sv
// Shared types and constants for the matmul tile bus sequencer.
// Optional feature macro: MATMUL_SEQ_PERF_EN (see matmul_bus_sequencer).
package matmul_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_M,
    LOAD_V,
    SETTLE,
    RD_ADDR,
    RD_CAP,
    EMIT
  } seqState_t;

  localparam int GLOBAL_DATA_WIDTH = 32;
  localparam int GLOBAL_ADDR_WIDTH = 15;

  localparam logic [GLOBAL_ADDR_WIDTH-1:0] ADDR_MATRIX = 15'd0;
  localparam logic [GLOBAL_ADDR_WIDTH-1:0] ADDR_VECTOR = 15'd1;

  // Counter width able to hold N*N (matrix word count).
  function automatic int cntWidth(input int n);
    return $clog2(n * n + 1);
  endfunction

endpackage

// File: rtl/matmul_seq_counter.sv
// Loadable up/down counter with terminal-value flag.
// Shared by the word, settle and result-index counters.
module matmul_seq_counter #(
  parameter int pWidth = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              load,
  input  logic [pWidth-1:0] loadValue,
  input  logic              up,
  input  logic              down,
  input  logic [pWidth-1:0] termValue,
  output logic [pWidth-1:0] count,
  output logic              atTerm
);

  // Load has priority over counting; up over down.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (up) begin
      count <= count + pWidth'(1);
    end else if (down) begin
      count <= count - pWidth'(1);
    end
  end

  assign atTerm = (count == termValue);

endmodule

// File: rtl/matmul_bus_sequencer.sv
// Host-side driver for the scan-mode matmul tile: loads matrix and
// vector, reads results back. Macro MATMUL_SEQ_PERF_EN adds cycCount.
module matmul_bus_sequencer
  import matmul_seq_pkg::*;
#(
  parameter int pVectorSize = 2,
  parameter int pWordSize   = 8,
  parameter int pSettle     = 2
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         inValid,
  output logic                         inReady,
  input  logic [pWordSize-1:0]         inData,
  output logic                         busRD,
  output logic                         busWR,
  output logic [GLOBAL_ADDR_WIDTH-1:0] busAddr,
  output logic [GLOBAL_DATA_WIDTH-1:0] busDataOut,
  input  logic [GLOBAL_DATA_WIDTH-1:0] busDataIn,
  output logic                         outValid,
  input  logic                         outReady,
  output logic [pWordSize-1:0]         outData,
  output logic                         outLast,
  output logic                         busy
`ifdef MATMUL_SEQ_PERF_EN
  ,
  output logic [15:0]                  cycCount
`endif
);

  localparam int CW = cntWidth(pVectorSize);
  localparam int SW = $clog2(pSettle + 1);

  localparam logic [CW-1:0] MAT_LAST =
    CW'(pVectorSize * pVectorSize - 1);
  localparam logic [CW-1:0] VEC_LAST = CW'(pVectorSize - 1);
  localparam logic [SW-1:0] SETTLE_INIT = SW'(pSettle);
  localparam logic [SW-1:0] SETTLE_TERM = SW'(1);

  seqState_t state;
  seqState_t stateNext;

  logic [CW-1:0] wordCnt;
  logic [CW-1:0] wordTerm;
  logic          wordAtTerm;
  logic          wordLoad;
  logic          wordUp;

  logic [SW-1:0] settleCnt;
  logic          settleAtTerm;
  logic          settleLoad;
  logic          settleDown;

  logic [CW-1:0] idxCnt;
  logic          idxAtTerm;
  logic          idxLoad;
  logic          idxUp;

  logic                 capture;
  logic                 finalHs;
  logic [pWordSize-1:0] dataHold;

  assign wordTerm = (state == LOAD_V) ? VEC_LAST : MAT_LAST;

  matmul_seq_counter #(.pWidth(CW)) uWordCnt (
    .Clk       (Clk),
    .Reset     (Reset),
    .load      (wordLoad),
    .loadValue ('0),
    .up        (wordUp),
    .down      (1'b0),
    .termValue (wordTerm),
    .count     (wordCnt),
    .atTerm    (wordAtTerm)
  );

  matmul_seq_counter #(.pWidth(SW)) uSettleCnt (
    .Clk       (Clk),
    .Reset     (Reset),
    .load      (settleLoad),
    .loadValue (SETTLE_INIT),
    .up        (1'b0),
    .down      (settleDown),
    .termValue (SETTLE_TERM),
    .count     (settleCnt),
    .atTerm    (settleAtTerm)
  );

  matmul_seq_counter #(.pWidth(CW)) uIdxCnt (
    .Clk       (Clk),
    .Reset     (Reset),
    .load      (idxLoad),
    .loadValue ('0),
    .up        (idxUp),
    .down      (1'b0),
    .termValue (VEC_LAST),
    .count     (idxCnt),
    .atTerm    (idxAtTerm)
  );

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state, bus strobes and counter controls.
  always_comb begin
    stateNext  = state;
    inReady    = 1'b0;
    busWR      = 1'b0;
    busRD      = 1'b0;
    busAddr    = ADDR_MATRIX;
    outValid   = 1'b0;
    outLast    = 1'b0;
    wordLoad   = 1'b0;
    wordUp     = 1'b0;
    settleLoad = 1'b0;
    settleDown = 1'b0;
    idxLoad    = 1'b0;
    idxUp      = 1'b0;
    capture    = 1'b0;
    finalHs    = 1'b0;
    unique case (state)
      IDLE: begin
        if (inValid) begin
          stateNext = LOAD_M;
          wordLoad  = 1'b1;
        end
      end
      LOAD_M: begin
        inReady = 1'b1;
        if (inValid) begin
          busWR  = 1'b1;
          wordUp = 1'b1;
          if (wordAtTerm) begin
            stateNext = LOAD_V;
            wordLoad  = 1'b1;
          end
        end
      end
      LOAD_V: begin
        inReady = 1'b1;
        busAddr = ADDR_VECTOR;
        if (inValid) begin
          busWR  = 1'b1;
          wordUp = 1'b1;
          if (wordAtTerm) begin
            stateNext  = SETTLE;
            settleLoad = 1'b1;
          end
        end
      end
      SETTLE: begin
        settleDown = 1'b1;
        if (settleAtTerm) begin
          stateNext = RD_ADDR;
          idxLoad   = 1'b1;
        end
      end
      RD_ADDR: begin
        busRD     = 1'b1;
        busAddr   = GLOBAL_ADDR_WIDTH'(idxCnt);
        stateNext = RD_CAP;
      end
      RD_CAP: begin
        busRD     = 1'b1;
        busAddr   = GLOBAL_ADDR_WIDTH'(idxCnt);
        capture   = 1'b1;
        stateNext = EMIT;
      end
      EMIT: begin
        outValid = 1'b1;
        outLast  = idxAtTerm;
        if (outReady) begin
          if (idxAtTerm) begin
            stateNext = IDLE;
            finalHs   = 1'b1;
          end else begin
            idxUp     = 1'b1;
            stateNext = RD_ADDR;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Hold last written word and capture the read-back result.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dataHold <= '0;
      outData  <= '0;
    end else begin
      if (busWR) begin
        dataHold <= inData;
      end
      if (capture) begin
        outData <= busDataIn[pWordSize-1:0];
      end
    end
  end

  assign busDataOut =
    GLOBAL_DATA_WIDTH'(busWR ? inData : dataHold);
  assign busy = (state != IDLE);

  generate
    if (pWordSize < GLOBAL_DATA_WIDTH) begin : gUnused
      logic unusedHigh;
      assign unusedHigh =
        ^busDataIn[GLOBAL_DATA_WIDTH-1:pWordSize];
    end
  endgenerate

`ifdef MATMUL_SEQ_PERF_EN
  logic [15:0] jobCnt;

  // Saturating job cycle counter, frozen on the last result.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      jobCnt   <= '0;
      cycCount <= '0;
    end else begin
      if (state == IDLE && stateNext != IDLE) begin
        jobCnt <= '0;
      end else if (jobCnt != 16'hFFFF) begin
        jobCnt <= jobCnt + 16'd1;
      end
      if (finalHs) begin
        cycCount <= jobCnt;
      end
    end
  end
`endif

endmodule
